key_expander: RTL and testbench
===============================

# key_expander

Sequential, parameterised AES key expander. From one cipher key it computes the full FIPS-197 round-key schedule for AES-128, AES-192 or AES-256, selected by parameter. It produces one 32-bit schedule word per clock and stores every word in an internal register bank. The encrypt and decrypt round engines read any round key by index once expansion completes. It trades the all-combinational ten-stage chain for a single shared word datapath with four S-box instances.

## Interface
- KEY_BITS, 128: cipher key width. Legal values are 128, 192 and 256; any other value is an elaboration error. Derived values: NK = KEY_BITS/32, NR = NK+6, NW = 4*(NR+1), i.e. 44, 52 or 60 words.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to expand key_in. Sampled only in IDLE.
- key_in  in  KEY_BITS  cipher key. Byte 0 is at the MSBs. Captured on the edge that accepts start.
- busy  out  1  high while expansion is in progress.
- done  out  1  registered single-cycle pulse when the last word has been written.
- keys_valid  out  1  level signal: the complete schedule for the last accepted key is stored.
- rd_round  in  4  round-key index, 0..NR.
- rd_key  out  128  round key rd_round, built as {w[4r], w[4r+1], w[4r+2], w[4r+3]} with w[4r] in bits 127:96. Combinational from the storage bank.

## Operation
- FSM states: IDLE and EXPAND. After EXPAND completes, the block returns to IDLE.
- IDLE to EXPAND, when start=1:
  - w[0..NK-1] <= key_in words, most significant word first.
  - Word counter i <= NK.
  - rcon <= 8'h01.
  - busy <= 1, keys_valid <= 0.
- EXPAND, each cycle:
  - temp = w[i-1].
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon <= xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1B : 0).
  - Else if NK == 8 and i mod NK == 4: temp = SubWord(temp).
  - w[i] <= w[i-NK] ^ temp; i <= i+1.
- When i == NW-1 is written: state <= IDLE, busy <= 0, done <= 1 for one cycle, keys_valid <= 1.
- The i mod NK term is a modulo counter that wraps at NK; no divider is used.
- start is ignored while busy=1. There is no queueing or restart.
- start in IDLE while keys_valid=1 overwrites the schedule. keys_valid drops on the accepting edge.
- rd_round > NR gives rd_key = 128'h0.
- During EXPAND, rd_key returns the current bank contents, which may be partial. Consumers gate on keys_valid.
- Reset values:
  - State IDLE.
  - busy, done and keys_valid are 0.
  - All storage words are 0.
  - rcon is 8'h01; the counter is 0.
  - With no key loaded, rd_key is 0 for every index.

## Timing
- The accepting edge is E0. Word writes occur on edges E1..E(NW-NK): 40, 46 or 52 edges for 128, 192 or 256.
- done and keys_valid go high after edge E(NW-NK). busy goes low on that same edge.
- done falls on the next edge.
- Throughput: one new key every NW-NK+1 cycles at most. start held high continuously re-expands after each done cycle.
- rst asserted mid-EXPAND:
  - All outputs clear immediately and asynchronously.
  - The partial schedule is discarded.
  - After deassertion, the first start behaves as after power-up.
- Worst-case combinational path: the storage read mux, the S-box, and two XORs into the word register.

## Test plan
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pulse start. Required: done exactly 40 cycles after the accepting edge; rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rd_round=0 gives the key.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b. Required: done after 46 cycles; rd_round=12 gives e98ba06f448c773c8ecc720401002202.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4. Required: done after 52 cycles; rd_round=14 gives fe4890d1e6188d0b046df344706c631e. This case exercises the i mod 8 == 4 SubWord path.
- Assert rst 20 cycles into an AES-128 expansion. Required: busy, done and keys_valid are 0 immediately and rd_key = 0. A restart then yields correct keys after 40 cycles.
- Pulse start with a different key while busy; then issue a new start while keys_valid=1. Required: the mid-run start has no effect and the first schedule is correct. The later start clears keys_valid on its accepting edge, and the second key's schedule replaces the first.
- Read rd_round=15 in AES-128 mode and rd_round=13 in AES-192 mode. Required: rd_key = 0 in both cases.

Source files
------------

// File: rtl/key_expander.sv
// Sequential AES key expander: one 32-bit schedule word per clock into a register bank,
// round keys read back by index. Key size (128/192/256) chosen by KEY_BITS.
module key_expander #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                done,
  output logic                keys_valid,
  input  logic [3:0]          rd_round,
  output logic [127:0]        rd_key
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("key_expander: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TBL[2047 - 8 * int'(a) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic {IDLE, EXPAND} state_t;
  state_t state, state_nxt;

  logic [31:0] w [NW];
  logic [5:0]  cnt;
  logic [2:0]  phase;
  logic [7:0]  rcon;
  logic        accept;
  logic        last;
  logic [31:0] prev;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == 6'(NW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EXPAND;
      EXPAND:  if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == EXPAND);
  end

  // phase tracks i mod NK; phase 0 takes RotWord+SubWord+Rcon, phase 4 of AES-256 SubWord only
  always_comb begin
    prev    = w[cnt - 6'd1];
    sub_in  = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (phase == 3'd0)                 temp = sub_out ^ {rcon, 24'h0};
    else if (NK == 8 && phase == 3'd4) temp = sub_out;
    else                               temp = prev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NW; j++) w[j] <= '0;
      cnt        <= '0;
      phase      <= '0;
      rcon       <= 8'h01;
      done       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        for (int j = 0; j < NK; j++) w[j] <= key_in[KEY_BITS-1-32*j -: 32];
        cnt        <= 6'(NK);
        phase      <= '0;
        rcon       <= 8'h01;
        keys_valid <= 1'b0;
      end else if (state == EXPAND) begin
        w[cnt] <= w[cnt - 6'(NK)] ^ temp;
        cnt    <= cnt + 6'd1;
        phase  <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
        if (phase == 3'd0) rcon <= xtime(rcon);
        if (last) begin
          done       <= 1'b1;
          keys_valid <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_key = '0;
    for (int r = 0; r <= NR; r++) begin
      if (rd_round == 4'(r)) rd_key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  end

endmodule

// File: tb/tb_key_expander.sv
// Bench for key_expander: AES-128/192/256 instances checked against a schedule model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_s    [3];
  logic [255:0] key_s      [3];
  logic [3:0]   rd_round_s [3];
  logic         busy_s     [3];
  logic         done_s     [3];
  logic         kv_s       [3];
  logic [127:0] rd_key_s   [3];

  int checks = 0;
  int errors = 0;

  logic [7:0]  sb    [256];
  logic [31:0] ref_w [3][60];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int KB = 128 + 64 * g;
    key_expander #(.KEY_BITS(KB)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start_s[g]),
      .key_in     (key_s[g][KB-1:0]),
      .busy       (busy_s[g]),
      .done       (done_s[g]),
      .keys_valid (kv_s[g]),
      .rd_round   (rd_round_s[g]),
      .rd_key     (rd_key_s[g])
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int n);
    logic [7:0] r = 8'h01;
    for (int j = 1; j < n; j++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_ref(input int k, input logic [255:0] kv);
    int nk = 4 + 2 * k;
    int nw = 4 * (nk + 7);
    logic [31:0] t;
    for (int i = 0; i < nk; i++) ref_w[k][i] = kv[32*nk-1-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = ref_w[k][i-1];
      if (i % nk == 0)                 t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
      else if (nk > 6 && i % nk == 4)  t = sub_word(t);
      ref_w[k][i] = ref_w[k][i-nk] ^ t;
    end
  endtask

  task automatic start_key(input int k, input logic [255:0] kv, input string tag);
    @(negedge clk);
    key_s[k]   = kv;
    start_s[k] = 1'b1;
    @(posedge clk);
    #1;
    start_s[k] = 1'b0;
    check_eq({tag, "_busy_e0"}, 128'(busy_s[k]), 128'd1);
    check_eq({tag, "_kv_e0"},   128'(kv_s[k]),   128'd0);
  endtask

  task automatic wait_done(input int k, input int exp_lat, input int n0, input string tag);
    int n = n0;
    while (!done_s[k] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_timeout"}, 128'(done_s[k]), 128'd1);
    check_eq({tag, "_latency"}, 128'(n), 128'(exp_lat));
    check_eq({tag, "_busy_end"}, 128'(busy_s[k]), 128'd0);
    check_eq({tag, "_kv_end"},   128'(kv_s[k]),   128'd1);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_fall"}, 128'(done_s[k]), 128'd0);
    check_eq({tag, "_kv_hold"},   128'(kv_s[k]),   128'd1);
  endtask

  task automatic check_sched(input int k, input string tag);
    int nr = 10 + 2 * k;
    for (int r = 0; r <= nr; r++) begin
      rd_round_s[k] = 4'(r);
      #1;
      check_eq($sformatf("%s_r%0d", tag, r), rd_key_s[k],
               {ref_w[k][4*r], ref_w[k][4*r+1], ref_w[k][4*r+2], ref_w[k][4*r+3]});
    end
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] fips [3];
    logic [127:0] last_rk [3];
    logic [255:0] ka, kb;
    fips[0] = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1] = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    fips[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    last_rk[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    last_rk[1] = 128'he98ba06f448c773c8ecc720401002202;
    last_rk[2] = 128'hfe4890d1e6188d0b046df344706c631e;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; key_s[k] = '0; rd_round_s[k] = 4'd0;
    end
    build_sbox();
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_busy%0d", k), 128'(busy_s[k]), 128'd0);
      check_eq($sformatf("rst_done%0d", k), 128'(done_s[k]), 128'd0);
      check_eq($sformatf("rst_kv%0d", k),   128'(kv_s[k]),   128'd0);
      check_eq($sformatf("rst_rk%0d", k),   rd_key_s[k],     128'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // FIPS-197 vectors for each key size
    for (int k = 0; k < 3; k++) begin
      string tag = $sformatf("fips%0d", 128 + 64 * k);
      build_ref(k, fips[k]);
      start_key(k, fips[k], tag);
      wait_done(k, 40 + 6 * k, 0, tag);
      check_sched(k, tag);
      rd_round_s[k] = 4'(10 + 2 * k);
      #1;
      check_eq({tag, "_last"}, rd_key_s[k], last_rk[k]);
      rd_round_s[k] = 4'd0;
      #1;
      check_eq({tag, "_first"}, rd_key_s[k], fips[k][127 + 64 * k -: 128]);
    end

    // random keys
    for (int k = 0; k < 3; k++) begin
      for (int rep = 0; rep < 3; rep++) begin
        string tag = $sformatf("rnd%0d_%0d", 128 + 64 * k, rep);
        ka = rand_key();
        build_ref(k, ka);
        start_key(k, ka, tag);
        wait_done(k, 40 + 6 * k, 0, tag);
        check_sched(k, tag);
      end
    end

    // reset mid-expansion
    start_key(0, rand_key(), "midrst");
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", 128'(busy_s[0]), 128'd0);
    check_eq("midrst_done", 128'(done_s[0]), 128'd0);
    check_eq("midrst_kv",   128'(kv_s[0]),   128'd0);
    for (int r = 0; r <= 10; r += 5) begin
      rd_round_s[0] = 4'(r);
      #1;
      check_eq($sformatf("midrst_rk%0d", r), rd_key_s[0], 128'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    build_ref(0, fips[0]);
    start_key(0, fips[0], "restart");
    wait_done(0, 40, 0, "restart");
    check_sched(0, "restart");

    // start while busy is ignored; start while keys_valid replaces the schedule
    ka = rand_key();
    kb = rand_key();
    build_ref(0, ka);
    start_key(0, ka, "busyA");
    repeat (5) @(negedge clk);
    key_s[0]   = kb;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    check_eq("busyA_still_busy", 128'(busy_s[0]), 128'd1);
    wait_done(0, 40, 5, "busyA");
    check_sched(0, "busyA");
    build_ref(0, kb);
    start_key(0, kb, "reloadB");
    wait_done(0, 40, 0, "reloadB");
    check_sched(0, "reloadB");

    // out-of-range round indices
    for (int k = 0; k < 3; k++) begin
      for (int r = 11 + 2 * k; r <= 15; r++) begin
        rd_round_s[k] = 4'(r);
        #1;
        check_eq($sformatf("oor%0d_r%0d", 128 + 64 * k, r), rd_key_s[k], 128'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
